// File: rtl/rst_seq.sv
// rst_seq -- reset and clock bring-up sequencer for the Propeller 1 top level.
//
// Holds the PLL in reset, waits for lock, stretches the core reset and then
// releases the active-low core reset nres. In RUN it arbitrates lock loss,
// the debounced reset button and the software reboot request, and records
// the cause of the most recent reset.
//
// Ports:
//   clk         in   sequencer clock (PLL reference domain)
//   res         in   asynchronous active-high reset
//   pll_locked  in   PLL lock, asynchronous (2-FF synchronized)
//   ext_resn    in   reset button, active-low, asynchronous (synced + debounced)
//   soft_res    in   software reboot request, level, synchronous to clk
//   pll_res     out  active-high PLL / clock-control reset
//   nres        out  active-low core reset, registered
//   rst_cause   out  00 power-on/res, 01 button, 10 soft, 11 lock loss/timeout
//
// Optional feature macro: RST_SEQ_LOCK_TIMEOUT_EN
//   defined     -> WAIT_LOCK gives up after LOCK_TIMEOUT cycles, re-pulses
//                  pll_res and records cause 11 (retries forever)
//   not defined -> WAIT_LOCK waits for lock indefinitely
module rst_seq #(
  parameter int CNT_W          = 24,
  parameter int PLL_RES_CYCLES = 8,
  parameter int STRETCH        = 160000,
  parameter int DEBOUNCE       = 16,
  parameter int LOCK_TIMEOUT   = 65535
) (
  input  logic       clk,
  input  logic       res,
  input  logic       pll_locked,
  input  logic       ext_resn,
  input  logic       soft_res,
  output logic       pll_res,
  output logic       nres,
  output logic [1:0] rst_cause
);

  typedef enum logic [2:0] {
    ST_PLLRST,
    ST_WAIT_LOCK,
    ST_STRETCH,
    ST_RUN,
    ST_HOLD
  } state_e;

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RES_CYCLES - 1);
  localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(STRETCH - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
`else
  // The timeout length is only meaningful when the timeout is built in.
  logic unused_lock_timeout;
  assign unused_lock_timeout = (LOCK_TIMEOUT == 0);
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_s1_q, lock_s1_d, lock_s2_q, lock_s2_d;
  logic             btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic             btn_db_q, btn_db_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             nres_q, nres_d;
  logic [1:0]       cause_q, cause_d;

  logic lock_ok, btn_pressed;

  always_comb begin
    // Two-stage synchronizers.
    lock_s1_d = pll_locked;
    lock_s2_d = lock_s1_q;
    btn_s1_d  = ext_resn;
    btn_s2_d  = btn_s1_q;

    // Debounce: count consecutive cycles where the synced level disagrees
    // with the accepted level; any agreement restarts the count.
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) btn_db_d = btn_s2_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign lock_ok     = lock_s2_q;
  assign btn_pressed = ~btn_db_q;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_PLLRST:    if (cnt_q == PLL_LAST) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_ok) state_d = ST_STRETCH;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = ST_PLLRST;
          cause_d = 2'b11;
        end
`endif
      end
      ST_STRETCH: begin
        if (!lock_ok) begin
          state_d = ST_PLLRST;
          cause_d = 2'b11;
        end else if (cnt_q == STR_LAST && !soft_res) begin
          state_d = ST_RUN;
        end
      end
      // Coincident events resolve as lock loss > button > soft.
      ST_RUN: begin
        if (!lock_ok) begin
          state_d = ST_PLLRST;
          cause_d = 2'b11;
        end else if (btn_pressed) begin
          state_d = ST_HOLD;
          cause_d = 2'b01;
        end else if (soft_res) begin
          state_d = ST_STRETCH;
          cause_d = 2'b10;
        end
      end
      // Losing lock while the button is held still has to restart the PLL.
      ST_HOLD: begin
        if (!lock_ok) begin
          state_d = ST_PLLRST;
          cause_d = 2'b11;
        end else if (!btn_pressed) begin
          state_d = ST_STRETCH;
        end
      end
      default: state_d = ST_PLLRST;
    endcase

    // Shared counter: cleared on every state change; STRETCH saturates so a
    // held soft_res keeps the core in reset without wrapping the count.
    if (state_d != state_q)                            cnt_d = '0;
    else if (state_q == ST_STRETCH && cnt_q == STR_LAST) cnt_d = cnt_q;
    else                                               cnt_d = cnt_q + 1'b1;

    nres_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= ST_PLLRST;
      cnt_q     <= '0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
      btn_db_q  <= 1'b1;
      db_cnt_q  <= '0;
      nres_q    <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lock_s1_q <= lock_s1_d;
      lock_s2_q <= lock_s2_d;
      btn_s1_q  <= btn_s1_d;
      btn_s2_q  <= btn_s2_d;
      btn_db_q  <= btn_db_d;
      db_cnt_q  <= db_cnt_d;
      nres_q    <= nres_d;
      cause_q   <= cause_d;
    end
  end

  assign pll_res   = (state_q == ST_PLLRST);
  assign nres      = nres_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Testbench for rst_seq. Inputs are driven on the falling edge so they are
// sampled at the following rising edge; outputs are observed on the falling
// edge after the rising edge they belong to. Expected edges are derived from
// the sequencer's timing rules (synchronizer delay, debounce length, state
// durations) with plain arithmetic.
module tb_rst_seq;

  localparam int P_PRC = 4;
  localparam int P_STR = 10;
  localparam int P_DB  = 3;
  localparam int P_TO  = 20;

  logic       clk;
  logic       res;
  logic       pll_locked;
  logic       ext_resn;
  logic       soft_res;
  logic       pll_res;
  logic       nres;
  logic [1:0] rst_cause;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  rst_seq #(
    .CNT_W          (24),
    .PLL_RES_CYCLES (P_PRC),
    .STRETCH        (P_STR),
    .DEBOUNCE       (P_DB),
    .LOCK_TIMEOUT   (P_TO)
  ) dut (
    .clk        (clk),
    .res        (res),
    .pll_locked (pll_locked),
    .ext_resn   (ext_resn),
    .soft_res   (soft_res),
    .pll_res    (pll_res),
    .nres       (nres),
    .rst_cause  (rst_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (pll_res !== 1'b1) begin errors++; $display("FAIL reset_pll_res got=%b exp=1", pll_res); end
    checks++;
    if (nres !== 1'b0) begin errors++; $display("FAIL reset_nres got=%b exp=0", nres); end
    checks++;
    if (rst_cause !== 2'b00) begin errors++; $display("FAIL reset_cause got=%b exp=00", rst_cause); end
  endtask

  // Release res now (edge 0 = last edge seen), raise lock sampled at edge L.
  task automatic test_powerup(input int l);
    int b, rise;
    logic exp_pll, exp_n;
    res = 1'b0;
    b = edge_cnt;
    // WAIT_LOCK is entered at edge P_PRC and decides from the next edge on.
    rise = max2(l + 2, P_PRC + 1) + P_STR;
    for (int e = b + 1; e <= b + rise + 3; e++) begin
      pll_locked = (e - b >= l);
      @(negedge clk);
      exp_pll = (e - b) < P_PRC;
      exp_n   = (e - b) >= rise;
      checks++;
      if (pll_res !== exp_pll) begin errors++; $display("FAIL powerup_pll_res edge=%0d got=%b exp=%b", e - b, pll_res, exp_pll); end
      checks++;
      if (nres !== exp_n) begin errors++; $display("FAIL powerup_nres edge=%0d got=%b exp=%b", e - b, nres, exp_n); end
    end
    checks++;
    if (rst_cause !== 2'b00) begin errors++; $display("FAIL powerup_cause got=%b exp=00", rst_cause); end
  endtask

  task automatic test_lock_loss();
    int e0, k, d, rise;
    logic exp_pll, exp_n;
    e0 = edge_cnt;
    k = e0 + 3 + int'($urandom_range(0, 5));
    d = int'($urandom_range(1, 8));
    // PLLRST from k+2 for P_PRC edges, then lock must be seen in WAIT_LOCK.
    rise = max2(k + d + 2, k + 2 + P_PRC + 1) + P_STR;
    for (int e = e0 + 1; e <= rise + 3; e++) begin
      pll_locked = !(e >= k && e < k + d);
      @(negedge clk);
      exp_pll = (e >= k + 2) && (e < k + 2 + P_PRC);
      exp_n   = (e < k + 2) || (e >= rise);
      checks++;
      if (pll_res !== exp_pll) begin errors++; $display("FAIL lockloss_pll_res edge=%0d got=%b exp=%b", e - k, pll_res, exp_pll); end
      checks++;
      if (nres !== exp_n) begin errors++; $display("FAIL lockloss_nres edge=%0d got=%b exp=%b", e - k, nres, exp_n); end
      if (e >= k + 2) begin
        checks++;
        if (rst_cause !== 2'b11) begin errors++; $display("FAIL lockloss_cause edge=%0d got=%b exp=11", e - k, rst_cause); end
      end
    end
  endtask

  task automatic test_button();
    int e0, b0, bn, b, h, fall, rise;
    logic exp_n;
    e0 = edge_cnt;
    b0 = e0 + 3;
    bn = int'($urandom_range(1, P_DB - 1));
    b  = b0 + bn + 6;
    h  = int'($urandom_range(P_DB + 1, 50));
    fall = b + 2 + P_DB;
    rise = b + h + 2 + P_DB + P_STR;
    for (int e = e0 + 1; e <= rise + 3; e++) begin
      ext_resn = !((e >= b0 && e < b0 + bn) || (e >= b && e < b + h));
      @(negedge clk);
      exp_n = (e < fall) || (e >= rise);
      checks++;
      if (nres !== exp_n) begin errors++; $display("FAIL button_nres edge=%0d got=%b exp=%b", e - b, nres, exp_n); end
      checks++;
      if (pll_res !== 1'b0) begin errors++; $display("FAIL button_pll_res edge=%0d got=%b exp=0", e - b, pll_res); end
    end
    checks++;
    if (rst_cause !== 2'b01) begin errors++; $display("FAIL button_cause got=%b exp=01", rst_cause); end
  endtask

  task automatic test_soft();
    int e0, k, k2, s, rise2;
    logic exp_n;
    e0 = edge_cnt;
    k  = e0 + 3;
    k2 = k + P_STR + 5;
    s  = int'($urandom_range(1, 30));
    rise2 = max2(k2 + s, k2 + P_STR);
    for (int e = e0 + 1; e <= rise2 + 3; e++) begin
      soft_res = (e == k) || (e >= k2 && e < k2 + s);
      @(negedge clk);
      exp_n = !((e >= k && e < k + P_STR) || (e >= k2 && e < rise2));
      checks++;
      if (nres !== exp_n) begin errors++; $display("FAIL soft_nres edge=%0d got=%b exp=%b", e - k, nres, exp_n); end
      checks++;
      if (pll_res !== 1'b0) begin errors++; $display("FAIL soft_pll_res edge=%0d got=%b exp=0", e - k, pll_res); end
      if (e >= k) begin
        checks++;
        if (rst_cause !== 2'b10) begin errors++; $display("FAIL soft_cause edge=%0d got=%b exp=10", e - k, rst_cause); end
      end
    end
  endtask

  // Lock loss, debounced button press and soft_res all land on edge k.
  task automatic test_simultaneous();
    int e0, k, rise;
    logic exp_pll, exp_n;
    e0 = edge_cnt;
    k = e0 + 8;
    rise = max2(k + 2, k + P_PRC + 1) + P_STR;
    for (int e = e0 + 1; e <= rise + 3; e++) begin
      ext_resn   = !(e >= k - 2 - P_DB && e <= k);
      pll_locked = !(e >= k - 2 && e < k);
      soft_res   = (e == k);
      @(negedge clk);
      exp_pll = (e >= k) && (e < k + P_PRC);
      exp_n   = (e < k) || (e >= rise);
      checks++;
      if (pll_res !== exp_pll) begin errors++; $display("FAIL simul_pll_res edge=%0d got=%b exp=%b", e - k, pll_res, exp_pll); end
      checks++;
      if (nres !== exp_n) begin errors++; $display("FAIL simul_nres edge=%0d got=%b exp=%b", e - k, nres, exp_n); end
      if (e >= k) begin
        checks++;
        if (rst_cause !== 2'b11) begin errors++; $display("FAIL simul_cause edge=%0d got=%b exp=11", e - k, rst_cause); end
      end
    end
  endtask

  task automatic test_reset_mid();
    #2;
    res = 1'b1;
    pll_locked = 1'b0;
    #1;
    checks++;
    if (pll_res !== 1'b1) begin errors++; $display("FAIL midreset_pll_res got=%b exp=1", pll_res); end
    checks++;
    if (nres !== 1'b0) begin errors++; $display("FAIL midreset_nres got=%b exp=0", nres); end
    checks++;
    if (rst_cause !== 2'b00) begin errors++; $display("FAIL midreset_cause got=%b exp=00", rst_cause); end
    @(negedge clk);
    test_powerup(int'($urandom_range(3, 15)));
  endtask

  task automatic test_timeout();
    int b, rel;
    logic exp_pll;
    logic [1:0] exp_c;
    res = 1'b1;
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    res = 1'b0;
    b = edge_cnt;
    for (int e = b + 1; e <= b + 3 * (P_PRC + P_TO) + 5; e++) begin
      @(negedge clk);
      rel = e - b;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
      exp_pll = (rel % (P_PRC + P_TO)) < P_PRC;
      exp_c   = (rel >= P_PRC + P_TO) ? 2'b11 : 2'b00;
`else
      exp_pll = rel < P_PRC;
      exp_c   = 2'b00;
`endif
      checks++;
      if (pll_res !== exp_pll) begin errors++; $display("FAIL timeout_pll_res edge=%0d got=%b exp=%b", rel, pll_res, exp_pll); end
      checks++;
      if (rst_cause !== exp_c) begin errors++; $display("FAIL timeout_cause edge=%0d got=%b exp=%b", rel, rst_cause, exp_c); end
      checks++;
      if (nres !== 1'b0) begin errors++; $display("FAIL timeout_nres edge=%0d got=%b exp=0", rel, nres); end
    end
  endtask

  initial begin
    res        = 1'b1;
    pll_locked = 1'b0;
    ext_resn   = 1'b1;
    soft_res   = 1'b0;
    test_reset();
    test_powerup(8);
    test_lock_loss();
    test_button();
    test_soft();
    test_simultaneous();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
